imem_prog_loader: RTL and testbench
===================================

Name: imem_prog_loader

Overview:
- Writes a program into the writable 16-bit instruction memory from an 8-bit byte stream (host/UART side). This is the write side of the instruction fetch port that the single-cycle core reads from.
- Holds the core in reset while loading.
- Releases the core only after a complete, checksum-verified image has been written.

Parameters:
- ADDR_W, 4, instruction word address width; capacity is 2^ADDR_W words.
- HOLD_AT_RESET, 1, reset value of cpu_hold: 1 holds the core until the first load, 0 lets the core run.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- start  input  1  one-cycle pulse that begins a load; ignored while busy=1.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  block accepts a byte this cycle. Combinational from state.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  16  instruction word for the write.
- cpu_hold  output  1  drives the core's reset input.
- busy  output  1  a load is in progress.
- done  output  1  last load succeeded. Level signal, cleared by start.
- err  output  1  last load failed. Level signal, cleared by start.
- word_count  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, err=0, word_count=0.
  - cpu_hold=HOLD_AT_RESET.
  - Reset mid-load abandons the load; words already written stay in memory.
- A byte transfer occurs on a rising clk edge when in_valid=1 and in_ready=1.
- in_ready=1 only in states LEN, HI, LO and CHK.
- Stream format: LEN byte N, then N words sent high byte first (2N bytes), then a CHK byte.
  - CHK = 8-bit wrap-around sum of the 2N data bytes. The LEN byte is excluded.
- State IDLE:
  - On start, go to LEN.
  - Same edge: set busy=1, cpu_hold=1, done=0, err=0, word_count=0; clear the address counter and the checksum accumulator.
- State LEN, on byte accepted:
  - N=0 or N>2^ADDR_W: go to ERR.
  - Otherwise latch N and go to HI.
- State HI: on byte accepted, store it as the high byte, add it to the checksum, go to LO.
- State LO: on byte accepted, add it to the checksum, go to WR.
- State WR (one cycle, in_ready=0):
  - mem_we=1, mem_addr=current word index, mem_wdata={hi,lo}.
  - All three are registered outputs, valid exactly in this cycle.
  - Then increment the index and word_count.
  - If word_count (after increment) equals N, go to CHK; otherwise go to HI.
- State CHK, on byte accepted:
  - Byte equals the checksum: go to DONE.
  - Otherwise go to ERR.
- State DONE (terminal):
  - done=1, busy=0, cpu_hold=0. Outputs update on the edge after CHK acceptance.
  - On start, go to LEN.
- State ERR (terminal):
  - err=1, busy=0, cpu_hold stays 1.
  - On start, go to LEN.
- Word address wrap is impossible because N≤2^ADDR_W is enforced. With N=2^ADDR_W the last write goes to address 2^ADDR_W−1.
- mem_we is never asserted outside WR.
- Minimum load time for N words: 1 (LEN) + 3N (HI, LO, WR) + 1 (CHK) cycles from the first accepted byte.
- in_valid gaps are tolerated in every input state: the state holds with no side effects.
- start asserted while busy=1 has no effect.
- start asserted on the same edge that enters DONE or ERR is ignored.

Test Plan:
- Nominal load:
  - Stimulus: reset, start, bytes 02 20 44 80 81 65, in_valid held high.
  - Response: mem_we pulses twice: addr0=0x2044, then addr1=0x8081.
  - done=1, cpu_hold=0, word_count=2.
  - Total 8 cycles from LEN acceptance to done.
- Bad checksum:
  - Stimulus: same stream, last byte 0x66.
  - Response: both words are written, err=1, done=0, cpu_hold=1, busy=0.
- Illegal length:
  - Stimulus: start, LEN=0x00; separately LEN=0x11 with ADDR_W=4.
  - Response: err=1 the next cycle, no mem_we pulse, word_count=0.
- Full-capacity load with stalls:
  - Stimulus: LEN=0x10, 16 words 0x0000..0x000F, in_valid dropped every other cycle.
  - Response: 16 writes to addresses 0..15 with mem_wdata=address, CHK=0x78 accepted, done=1.
  - in_ready=0 in every WR cycle.
- Reset mid-load:
  - Stimulus: assert reset while in LO after 1 word has been written.
  - Response: all outputs return to reset values immediately (asynchronously), cpu_hold=1.
  - A subsequent start plus a full stream loads correctly.
- Start while busy:
  - Stimulus: pulse start during HI.
  - Response: no state change, word_count not cleared, load completes normally.

Source files
------------

// File: rtl/imem_prog_loader.sv
// Instruction-memory program loader: writes a length-prefixed, checksummed byte stream
// into the 16-bit instruction memory, holding the core in reset until a verified image lands.
module imem_prog_loader #(
  parameter int ADDR_W        = 4,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising clk edge when in_valid && in_ready; in_ready is a
  // pure function of state, and the source may hold in_valid low for any number of cycles.

  localparam int unsigned CAP = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WR   = 3'd4,
    S_CHK  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic              accept;
  logic              start_ok;
  logic              len_ok;
  logic              csum_ok;
  logic              last_word;
  logic [ADDR_W:0]   wc_inc;

  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  assign accept    = in_valid & in_ready;
  assign len_ok    = (in_data != 8'd0) && ({24'd0, in_data} <= CAP);
  assign csum_ok   = (in_data == csum_q);
  assign wc_inc    = wc_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (wc_inc == n_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LEN;
      S_LEN:                 if (accept) state_d = len_ok ? S_HI : S_ERR;
      S_HI:                  if (accept) state_d = S_LO;
      S_LO:                  if (accept) state_d = S_WR;
      S_WR:                  state_d = last_word ? S_CHK : S_HI;
      S_CHK:                 if (accept) state_d = csum_ok ? S_DONE : S_ERR;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      S_LEN, S_HI, S_LO, S_CHK: in_ready = 1'b1;
      S_IDLE, S_DONE, S_ERR:    start_ok = start;
      default: ;
    endcase
  end

  // Registered side effects of each transition; the memory write port is loaded on the
  // LO acceptance edge so it is valid for exactly the WR cycle.
  always_comb begin
    n_d         = n_q;
    wc_d        = wc_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          busy_d = 1'b1;
          hold_d = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
          wc_d   = '0;
          csum_d = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (len_ok) begin
            n_d = (ADDR_W+1)'(in_data);
          end else begin
            err_d  = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d   = in_data;
          csum_d = csum_q + in_data;
        end
      end
      S_LO: begin
        if (accept) begin
          csum_d      = csum_q + in_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = wc_q[ADDR_W-1:0];
          mem_wdata_d = {hi_q, in_data};
        end
      end
      S_WR: begin
        wc_d = wc_inc;
      end
      S_CHK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (csum_ok) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= '0;
      wc_q        <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= HOLD_AT_RESET;
    end else begin
      n_q         <= n_d;
      wc_q        <= wc_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: table vectors, hand-written corner sequences and random loads
// checked against a stream-level model and a write scoreboard.
`timescale 1ns/1ps
module tb_imem_prog_loader;

  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;
  localparam int WW     = ADDR_W + 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;
  logic [2:0]        dbg_state;

  imem_prog_loader #(.ADDR_W(ADDR_W), .HOLD_AT_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- write scoreboard ----------------
  logic [WW-1:0] exp_q[$];

  always @(negedge clk) begin : wr_mon
    logic [WW-1:0] e;
    if (!reset && mem_we) begin
      chk("in_ready_in_wr", in_ready, 1'b0);
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_write", {mem_addr, mem_wdata}, e);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic [7:0] s[$], output logic ok, output int wc);
    int n, sum;
    n = s[0];
    if (n == 0 || n > CAP) begin
      ok = 1'b0;
      wc = 0;
    end else begin
      sum = 0;
      for (int i = 1; i <= 2 * n; i++) sum += s[i];
      ok = ((sum % 256) == s[2 * n + 1]);
      wc = n;
    end
  endfunction

  function automatic void push_writes(input logic [7:0] s[$]);
    int n;
    n = s[0];
    if (n != 0 && n <= CAP)
      for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), s[1 + 2 * i], s[2 + 2 * i]});
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_hold", cpu_hold, 1'b1);
    chk("start_done_clr", done, 1'b0);
    chk("start_err_clr", err, 1'b0);
    chk("start_wc_clr", word_count, 0);
    chk("start_in_ready", in_ready, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic final_check(input logic exp_done, input int exp_wc);
    chk("done", done, exp_done);
    chk("err", err, !exp_done);
    chk("busy_end", busy, 1'b0);
    chk("cpu_hold_end", cpu_hold, !exp_done);
    chk("word_count", word_count, exp_wc);
    chk("in_ready_terminal", in_ready, 1'b0);
    idle_cycles(2);
    chk("terminal_hold", {done, err, busy}, {exp_done, !exp_done, 1'b0});
    chk("writes_drained", exp_q.size(), 0);
  endtask

  task automatic run_load(input logic [7:0] s[$], input int gmin, input int gmax,
                          input logic exp_done, input int exp_wc);
    int n, t_len, t_end;
    n = s[0];
    push_writes(s);
    pulse_start();
    t_len = 0;
    foreach (s[i]) begin
      send_byte(s[i], $urandom_range(gmax, gmin));
      if (i == 0) t_len = cyc;
    end
    t_end = cyc;
    if (gmax == 0 && n != 0 && n <= CAP) chk("load_cycles", t_end - t_len + 1, 3 * n + 2);
    final_check(exp_done, exp_wc);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         len;
    logic [7:0] b [8];
    logic       exp_done;
    int         exp_wc;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #5ms;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    logic [7:0] s[$];
    logic       m_ok;
    int         m_wc, n, sum;
    logic [7:0] cb;

    vecs[0] = '{6, '{8'h02, 8'h20, 8'h44, 8'h80, 8'h81, 8'h65, 8'h00, 8'h00}, 1'b1, 2};
    vecs[1] = '{6, '{8'h02, 8'h20, 8'h44, 8'h80, 8'h81, 8'h66, 8'h00, 8'h00}, 1'b0, 2};
    vecs[2] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0};
    vecs[3] = '{1, '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0};
    vecs[4] = '{4, '{8'h01, 8'h12, 8'h34, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1};
    vecs[5] = '{4, '{8'h01, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1};
    vecs[6] = '{8, '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 3};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle_cycles(3);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_word_count", word_count, 0);
    chk("rst_cpu_hold", cpu_hold, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    idle_cycles(2);
    chk("idle_hold", {cpu_hold, busy, in_ready}, 3'b100);

    // Table vectors, back-to-back bytes
    for (int v = 0; v < 7; v++) begin
      s = {};
      for (int j = 0; j < vecs[v].len; j++) s.push_back(vecs[v].b[j]);
      run_load(s, 0, 0, vecs[v].exp_done, vecs[v].exp_wc);
    end

    // Full capacity, in_valid dropped every other cycle
    s = {};
    s.push_back(8'h10);
    for (int i = 0; i < 16; i++) begin
      s.push_back(8'h00);
      s.push_back(8'(i));
    end
    s.push_back(8'h78);
    run_load(s, 1, 1, 1'b1, 16);

    // Reset mid-load while in LO after one word written
    pulse_start();
    exp_q.push_back({ADDR_W'(0), 16'hABCD});
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h11, 0);
    chk("pre_reset_wc", word_count, 1);
    chk("pre_reset_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_mem_we", mem_we, 1'b0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_mem_wdata", mem_wdata, 0);
    chk("async_flags", {busy, done, err}, 3'b000);
    chk("async_word_count", word_count, 0);
    chk("async_cpu_hold", cpu_hold, 1'b1);
    chk("async_in_ready", in_ready, 1'b0);
    chk("async_writes_drained", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    s = {8'h02, 8'h20, 8'h44, 8'h80, 8'h81, 8'h65};
    run_load(s, 0, 0, 1'b1, 2);

    // Start pulsed during HI is ignored
    s = {8'h02, 8'h20, 8'h44, 8'h80, 8'h81, 8'h65};
    push_writes(s);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h44, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_wc", word_count, 1);
    chk("busy_start_busy", busy, 1'b1);
    chk("busy_start_in_ready", in_ready, 1'b1);
    send_byte(8'h80, 0);
    send_byte(8'h81, 0);
    send_byte(8'h65, 0);
    final_check(1'b1, 2);

    // Start on the edge that enters DONE is ignored
    exp_q.push_back({ADDR_W'(0), 16'h1234});
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    in_valid = 1'b1;
    in_data  = 8'h46;
    @(negedge clk);
    chk("chk_state_ready", in_ready, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    final_check(1'b1, 1);

    // Random loads against the model
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(5, 0) == 0)
        n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, CAP + 1);
      else
        n = $urandom_range(CAP, 1);
      s = {};
      s.push_back(8'(n));
      if (n != 0 && n <= CAP) begin
        sum = 0;
        for (int i = 0; i < 2 * n; i++) begin
          cb = 8'($urandom);
          sum += cb;
          s.push_back(cb);
        end
        if ($urandom_range(3, 0) == 0) s.push_back(8'(sum + 1 + $urandom_range(254, 0)));
        else s.push_back(8'(sum));
      end
      model(s, m_ok, m_wc);
      run_load(s, 0, $urandom_range(2, 0), m_ok, m_wc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
